// File: rtl/pingpong_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module   : pingpong_frame_buffer
// Purpose  : Two-bank frame store. Frames stream into the back bank while the
//            front bank is read at random; completed frames swap in atomically.
// Revision : 1.0 - initial release
// ============================================================================
module pingpong_frame_buffer #(
  parameter int PIX_WIDTH    = 16,
  parameter int IMG_WIDTH    = 176,
  parameter int IMG_HEIGHT   = 240,
  parameter int TOTAL_PIXELS = IMG_WIDTH * IMG_HEIGHT,
  parameter int ADDR_WIDTH   = $clog2(TOTAL_PIXELS),
  parameter int CNT_WIDTH    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  input  logic                  wr_sof,
  input  logic [PIX_WIDTH-1:0]  wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_lock,
  output logic [PIX_WIDTH-1:0]  rd_data,
  output logic                  rd_valid,
  output logic                  front_bank,
  output logic                  frame_avail,
  output logic                  frame_swap,
  output logic                  err_short,
  output logic [CNT_WIDTH-1:0]  drop_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_PEND = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] c_last  = ADDR_WIDTH'(TOTAL_PIXELS - 1);
  localparam logic [ADDR_WIDTH:0]   c_total = (ADDR_WIDTH + 1)'(TOTAL_PIXELS);
  localparam logic [ADDR_WIDTH-1:0] c_one   = ADDR_WIDTH'(1);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [PIX_WIDTH-1:0]  r_bank0 [TOTAL_PIXELS];
  logic [PIX_WIDTH-1:0]  r_bank1 [TOTAL_PIXELS];

  logic                  w_wr_en;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic                  w_rd_in_range;
  logic [ADDR_WIDTH-1:0] w_rd_idx;
  logic [PIX_WIDTH-1:0]  w_rd_word;

  always_comb begin
    w_wr_en       = rst_n && wr_valid &&
                    (((r_state == S_IDLE) && wr_sof) || (r_state == S_FILL));
    w_wr_addr     = wr_sof ? '0 : r_wr_ptr;
    w_rd_in_range = ({1'b0, rd_addr} < c_total);
    // Clamp the index so out-of-range reads never touch a nonexistent word
    w_rd_idx      = w_rd_in_range ? rd_addr : '0;
    w_rd_word     = front_bank ? r_bank1[w_rd_idx] : r_bank0[w_rd_idx];
  end

  // Writes always land in the bank that is not currently being read
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      if (front_bank) r_bank0[w_wr_addr] <= wr_data;
      else            r_bank1[w_wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      front_bank  <= 1'b0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      frame_avail <= 1'b0;
      frame_swap  <= 1'b0;
      err_short   <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      frame_swap <= 1'b0;
      err_short  <= 1'b0;
      rd_valid   <= rd_en;
      if (rd_en) rd_data <= w_rd_in_range ? w_rd_word : '0;

      case (r_state)
        S_IDLE: begin
          if (wr_valid && wr_sof) begin
            r_wr_ptr <= c_one;
            r_state  <= S_FILL;
          end
        end
        S_FILL: begin
          if (wr_valid) begin
            if (wr_sof) begin
              r_wr_ptr  <= c_one;
              err_short <= 1'b1;
            end else if (r_wr_ptr == c_last) begin
              r_wr_ptr <= '0;
              if (rd_lock) begin
                r_state <= S_PEND;
              end else begin
                front_bank  <= ~front_bank;
                frame_swap  <= 1'b1;
                frame_avail <= 1'b1;
                r_state     <= S_IDLE;
              end
            end else begin
              r_wr_ptr <= r_wr_ptr + c_one;
            end
          end
        end
        S_PEND: begin
          // A new frame arriving here has nowhere to go; count it and let IDLE skip the rest
          if (wr_valid && wr_sof && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
          if (!rd_lock) begin
            front_bank  <= ~front_bank;
            frame_swap  <= 1'b1;
            frame_avail <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
